// File: rtl/seven_seg_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, decodes each digit back to its hex
// nibble and hands completed frames out on a valid/ready port.
// Optional: SEVSEG_BLANK_DETECT_EN decodes the all-off pattern as a blank digit.
module seven_seg_scan_decoder #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_n,
    input  logic [NDIG-1:0]   an_n,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [4*NDIG-1:0] out_data,
    output logic [NDIG-1:0]   out_err,
    output logic [NDIG-1:0]   out_blank,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int unsigned   CW      = $clog2(STABLE_CYC);
    localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYC - 2);

    typedef struct packed {
        logic       blank;
        logic       err;
        logic [3:0] nib;
    } dec_t;

    typedef enum logic {EMPTY, FULL} state_e;

    function automatic dec_t decode(input logic [6:0] s);
        dec_t d;
        d = '{blank: 1'b0, err: 1'b0, nib: 4'h0};
        case (s)
            7'b0000001: d.nib = 4'h0;
            7'b1001111: d.nib = 4'h1;
            7'b0010010: d.nib = 4'h2;
            7'b0000110: d.nib = 4'h3;
            7'b1001100: d.nib = 4'h4;
            7'b0100100: d.nib = 4'h5;
            7'b0100000: d.nib = 4'h6;
            7'b0001111: d.nib = 4'h7;
            7'b0000000: d.nib = 4'h8;
            7'b0000100: d.nib = 4'h9;
            7'b0001000: d.nib = 4'hA;
            7'b1100000: d.nib = 4'hB;
            7'b0110001: d.nib = 4'hC;
            7'b1000010: d.nib = 4'hD;
            7'b0110000: d.nib = 4'hE;
            7'b0111000: d.nib = 4'hF;
`ifdef SEVSEG_BLANK_DETECT_EN
            7'b1111111: d.blank = 1'b1;
`endif
            default:    d.err = 1'b1;
        endcase
        return d;
    endfunction

    logic [6:0]        seg_q, seg_p_q;
    logic [NDIG-1:0]   an_q, an_p_q;
    logic [CW-1:0]     stab_q, stab_d;
    logic [4*NDIG-1:0] frame_q, frame_d;
    logic [NDIG-1:0]   err_q, err_d, blank_q, blank_d, seen_q, seen_d;
    logic              same, one_low, capture, complete;
    dec_t              dec;
    state_e            state_q;

    always_comb begin
        int unsigned n_low;
        n_low = 0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (!an_q[k]) n_low = n_low + 1;
        end
        one_low = (n_low == 1);

        same   = ({seg_q, an_q} == {seg_p_q, an_p_q});
        stab_d = !same ? '0 : ((stab_q == CNT_SAT) ? CNT_SAT : stab_q + 1'b1);
        // Fires only on the transition into saturation, so once per stable run.
        capture = same && (stab_q == CNT_PRE) && one_low;
        dec     = decode(seg_q);

        frame_d = frame_q;
        err_d   = err_q;
        blank_d = blank_q;
        seen_d  = seen_q;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (capture && !an_q[k]) begin
                frame_d[4*k +: 4] = dec.nib;
                err_d[k]          = dec.err;
                blank_d[k]        = dec.blank;
                seen_d[k]         = 1'b1;
            end
        end
        complete = capture && (seen_d == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= '0;
            seg_p_q <= '0;
            an_q    <= '0;
            an_p_q  <= '0;
            stab_q  <= '0;
            frame_q <= '0;
            err_q   <= '0;
            blank_q <= '0;
            seen_q  <= '0;
        end else begin
            seg_q   <= seg_n;
            seg_p_q <= seg_q;
            an_q    <= an_n;
            an_p_q  <= an_q;
            stab_q  <= stab_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            blank_q <= blank_d;
            seen_q  <= complete ? '0 : seen_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= '0;
            out_blank <= '0;
            overflow  <= 1'b0;
        end else begin
            // A frame completing while the held one is unaccepted is dropped.
            if (state_q == FULL && !out_ready && complete) overflow <= 1'b1;
            else if (clr_ovf)                             overflow <= 1'b0;

            if (complete && (state_q == EMPTY || out_ready)) begin
                state_q   <= FULL;
                out_valid <= 1'b1;
                out_data  <= frame_d;
                out_err   <= err_d;
                out_blank <= blank_d;
            end else if (state_q == FULL && out_ready) begin
                state_q   <= EMPTY;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed scan sequences checked against a
// cycle-level behavioural model plus hand-computed frame expectations.
module tb_seven_seg_scan_decoder;

    localparam int unsigned NDIG       = 4;
    localparam int unsigned STABLE_CYC = 4;
    localparam logic [6:0] TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic        clk, rst_n, out_ready, clr_ovf;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        out_valid, overflow;
    logic [15:0] out_data;
    logic [3:0]  out_err, out_blank;

    seven_seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_err(out_err), .out_blank(out_blank), .overflow(overflow),
        .clr_ovf(clr_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic void mdec(input logic [6:0] s, output logic [3:0] n,
                                 output logic e, output logic b);
        n = 4'h0; e = 1'b1; b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (s == TAB[i]) begin
                n = i[3:0];
                e = 1'b0;
            end
        end
`ifdef SEVSEG_BLANK_DETECT_EN
        if (s == 7'b1111111) begin
            e = 1'b0;
            b = 1'b1;
        end
`endif
    endfunction

    // Model: a digit is taken once its pin value has been steady for STABLE_CYC
    // cycles; its effect lands two edges after the last of those cycles.
    logic        exp_valid, exp_ovf;
    logic [15:0] exp_data;
    logic [3:0]  exp_err, exp_blank;

    initial begin
        logic [3:0]  m_nib [4];
        logic [3:0]  m_err, m_blank, m_seen;
        logic [10:0] m_prev, cur;
        int          m_run, lows, pk;
        logic        pv, pe, pb, complete, ovf_set;
        logic [3:0]  pn;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
                m_err = '0; m_blank = '0; m_seen = '0;
                m_prev = '0; m_run = 0;
                pv = 1'b0; pk = 0; pn = '0; pe = 1'b0; pb = 1'b0;
                exp_valid = 1'b0; exp_ovf = 1'b0;
                exp_data = '0; exp_err = '0; exp_blank = '0;
            end else begin
                complete = 1'b0;
                if (pv) begin
                    m_nib[pk] = pn; m_err[pk] = pe; m_blank[pk] = pb; m_seen[pk] = 1'b1;
                    complete = (m_seen == 4'hF);
                end
                ovf_set = exp_valid && !out_ready && complete;
                if (complete && (!exp_valid || out_ready)) begin
                    exp_valid = 1'b1;
                    exp_data  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    exp_err   = m_err;
                    exp_blank = m_blank;
                end else if (exp_valid && out_ready) begin
                    exp_valid = 1'b0;
                end
                if (ovf_set)      exp_ovf = 1'b1;
                else if (clr_ovf) exp_ovf = 1'b0;
                if (complete) m_seen = '0;

                cur = {seg_n, an_n};
                if (cur == m_prev) m_run++;
                else m_run = 1;
                m_prev = cur;
                lows = 0;
                for (int i = 0; i < 4; i++) if (!an_n[i]) begin lows++; pk = i; end
                pv = (m_run == STABLE_CYC) && (lows == 1);
                if (pv) mdec(seg_n, pn, pe, pb);
            end
        end
    end

    logic        cmp_en = 1'b0;
    int          vcount = 0;
    logic [15:0] last_data;
    logic [3:0]  last_err, last_blank;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("valid", {31'b0, out_valid}, {31'b0, exp_valid});
                chk("data", {16'b0, out_data}, {16'b0, exp_data});
                chk("err", {28'b0, out_err}, {28'b0, exp_err});
                chk("blank", {28'b0, out_blank}, {28'b0, exp_blank});
                chk("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
            end
            if (out_valid) begin
                vcount++;
                last_data  = out_data;
                last_err   = out_err;
                last_blank = out_blank;
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int unsigned d, input logic [6:0] pat, input int unsigned n);
        logic [3:0] one;
        one   = 4'b0001;
        seg_n = pat;
        an_n  = ~(one << d);
        step(n);
    endtask

    task automatic idle(input int unsigned n);
        seg_n = '1;
        an_n  = '1;
        step(n);
    endtask

    task automatic frame4(input logic [6:0] pat);
        for (int unsigned d = 0; d < 4; d++) show(d, pat, 8);
    endtask

    initial begin
        rst_n = 1'b0; seg_n = '1; an_n = '1; out_ready = 1'b1; clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        step(2);
        rst_n = 1'b1;
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_data", {16'b0, out_data}, 32'd0);
        chk("reset_ovf", {31'b0, overflow}, 32'd0);
        idle(4);

        // Basic frame 1,2,3,4
        vcount = 0;
        show(0, TAB[1], 8); show(1, TAB[2], 8); show(2, TAB[3], 8); show(3, TAB[4], 8);
        idle(10);
        chk("t1_pulses", vcount, 32'd1);
        chk("t1_data", {16'b0, last_data}, 32'h4321);
        chk("t1_err", {28'b0, last_err}, 32'd0);

        // Short glitch on digit 1 is not captured
        vcount = 0;
        show(0, TAB[5], 8); show(1, TAB[2], 3); show(1, TAB[3], 8);
        show(2, TAB[7], 8); show(3, TAB[8], 8);
        idle(10);
        chk("t2_pulses", vcount, 32'd1);
        chk("t2_data", {16'b0, last_data}, 32'h8735);

        // Unknown pattern and invalid digit enables
        vcount = 0;
        show(0, TAB[0], 8);
        seg_n = TAB[6]; an_n = 4'b1111; step(8);
        seg_n = TAB[6]; an_n = 4'b1100; step(8);
        show(1, TAB[9], 8); show(2, 7'b1111110, 8); show(3, TAB[15], 8);
        idle(10);
        chk("t3_pulses", vcount, 32'd1);
        chk("t3_data", {16'b0, last_data}, 32'hF090);
        chk("t3_err", {28'b0, last_err}, 32'h4);

        // Back-pressure: second frame dropped, overflow sticky
        out_ready = 1'b0;
        frame4(TAB[10]); frame4(TAB[5]);
        idle(8);
        chk("t4_valid_held", {31'b0, out_valid}, 32'd1);
        chk("t4_data_held", {16'b0, out_data}, 32'hAAAA);
        chk("t4_ovf", {31'b0, overflow}, 32'd1);
        out_ready = 1'b1;
        step(1);
        chk("t4_accept", {31'b0, out_valid}, 32'd0);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("t4_clr", {31'b0, overflow}, 32'd0);

        // Clear held across a new overflow
        out_ready = 1'b0;
        frame4(TAB[1]);
        clr_ovf = 1'b1;
        frame4(TAB[2]);
        idle(8);
        clr_ovf = 1'b0;
        chk("t4b_data_held", {16'b0, out_data}, 32'h1111);
        chk("t4b_ovf_cleared", {31'b0, overflow}, 32'd0);
        out_ready = 1'b1;
        step(2);

        // Reset mid-frame
        show(0, TAB[1], 8); show(1, TAB[2], 8);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data", {16'b0, out_data}, 32'd0);
        chk("t5_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_rst_err", {28'b0, out_err}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        vcount = 0;
        show(2, TAB[6], 8); show(3, TAB[7], 8);
        idle(10);
        chk("t5_no_early", vcount, 32'd0);
        show(0, TAB[8], 8); show(1, TAB[9], 8);
        idle(10);
        chk("t5_pulses", vcount, 32'd1);
        chk("t5_data", {16'b0, last_data}, 32'h7698);

        // All-off pattern on digit 3
        vcount = 0;
        show(0, TAB[1], 8); show(1, TAB[2], 8); show(2, TAB[3], 8); show(3, 7'b1111111, 8);
        idle(10);
        chk("t6_pulses", vcount, 32'd1);
        chk("t6_data", {16'b0, last_data}, 32'h0321);
`ifdef SEVSEG_BLANK_DETECT_EN
        chk("t6_blank", {28'b0, last_blank}, 32'h8);
        chk("t6_err", {28'b0, last_err}, 32'h0);
`else
        chk("t6_blank", {28'b0, last_blank}, 32'h0);
        chk("t6_err", {28'b0, last_err}, 32'h8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
